// File: rtl/enemy_scheduler.sv
// Per-game-tick enemy sequencer: scans the battlefront, routes player damage,
// strobes movement and periodically spawns a new enemy into the lowest free slot.
module enemy_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int SPAWN_INTERVAL = 8,
    parameter int POS_W          = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       gameTick,
    input  logic                       enable,
    input  logic [NUM_SLOTS-1:0]       slotAlive,
    input  logic [NUM_SLOTS*POS_W-1:0] slotPos,
    input  logic [POS_W-1:0]           playerFront,
    input  logic [7:0]                 playerDamage,
    output logic [NUM_SLOTS-1:0]       moveSCEN,
    output logic [NUM_SLOTS-1:0]       damageSCEN,
    output logic [7:0]                 damageIn,
    output logic [NUM_SLOTS-1:0]       spawn,
    output logic [POS_W-1:0]           enemyFront,
    output logic [7:0]                 waveCount,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [7:0] SPAWN_DUE = 8'(SPAWN_INTERVAL - 1);

    typedef enum logic [2:0] {
        QI,
        QScan,
        QDamage,
        QMove,
        QSpawn
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic [IDX_W-1:0]     acc_idx;
    logic [IDX_W-1:0]     acc_idx_next;
    logic [POS_W-1:0]     acc;
    logic [POS_W-1:0]     acc_next;
    logic [POS_W-1:0]     front_next;
    logic [POS_W-1:0]     scan_pos;
    logic                 found;
    logic                 found_next;
    logic [7:0]           spawn_count;
    logic [7:0]           spawn_count_next;
    logic [7:0]           wave_next;
    logic [7:0]           damage_in_next;
    logic [NUM_SLOTS-1:0] move_next;
    logic [NUM_SLOTS-1:0] damage_next;
    logic [NUM_SLOTS-1:0] spawn_next;
    logic [NUM_SLOTS-1:0] free_slots;
    logic [NUM_SLOTS-1:0] free_onehot;
    logic                 any_free;
    logic                 overrun_next;

    // Isolating the lowest set bit of the free mask picks the lowest free slot.
    assign free_slots  = ~slotAlive;
    assign free_onehot = free_slots & (~free_slots + NUM_SLOTS'(1));
    assign any_free    = |free_slots;
    assign scan_pos    = slotPos[idx*POS_W +: POS_W];

    always_comb begin
        state_next       = state;
        idx_next         = idx;
        acc_next         = acc;
        acc_idx_next     = acc_idx;
        found_next       = found;
        front_next       = enemyFront;
        spawn_count_next = spawn_count;
        wave_next        = waveCount;
        move_next        = '0;
        damage_next      = '0;
        damage_in_next   = '0;
        spawn_next       = '0;
        overrun_next     = overrun | (gameTick && (state != QI));

        case (state)
            QI: begin
                if (gameTick && enable) begin
                    state_next   = QScan;
                    idx_next     = '0;
                    acc_next     = '0;
                    acc_idx_next = '0;
                    found_next   = 1'b0;
                end
            end
            QScan: begin
                // Strictly-greater keeps the lowest index on a positional tie.
                if (slotAlive[idx] && (!found || (scan_pos > acc))) begin
                    acc_next     = scan_pos;
                    acc_idx_next = idx;
                    found_next   = 1'b1;
                end
                if (idx == LAST_IDX) begin
                    front_next = acc_next;
                    state_next = QDamage;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            QDamage: begin
                if (found && (enemyFront >= playerFront) && (playerDamage != 8'd0)) begin
                    damage_next    = NUM_SLOTS'(1) << acc_idx;
                    damage_in_next = playerDamage;
                end
                state_next = QMove;
            end
            QMove: begin
                move_next  = slotAlive;
                state_next = QSpawn;
            end
            QSpawn: begin
                // A due spawn with no free slot leaves the counter parked so it retries next tick.
                if (spawn_count >= SPAWN_DUE) begin
                    if (any_free) begin
                        spawn_next       = free_onehot;
                        spawn_count_next = 8'd0;
                        if (waveCount != 8'hFF) begin
                            wave_next = waveCount + 8'd1;
                        end
                    end
                end else begin
                    spawn_count_next = spawn_count + 8'd1;
                end
                state_next = QI;
            end
            default: begin
                state_next = QI;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= QI;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            acc         <= '0;
            acc_idx     <= '0;
            found       <= 1'b0;
            spawn_count <= 8'd0;
            moveSCEN    <= '0;
            damageSCEN  <= '0;
            damageIn    <= 8'd0;
            spawn       <= '0;
            enemyFront  <= '0;
            waveCount   <= 8'd0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            idx         <= idx_next;
            acc         <= acc_next;
            acc_idx     <= acc_idx_next;
            found       <= found_next;
            spawn_count <= spawn_count_next;
            moveSCEN    <= move_next;
            damageSCEN  <= damage_next;
            damageIn    <= damage_in_next;
            spawn       <= spawn_next;
            enemyFront  <= front_next;
            waveCount   <= wave_next;
            busy        <= (state != QI);
            overrun     <= overrun_next;
        end
    end

endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed bench for enemy_scheduler: fixed tick windows with hand-computed
// strobe values, spawn cadence, overrun and mid-sequence reset.
module tb_enemy_scheduler;

    logic        clk;
    logic        reset;
    logic        gameTick;
    logic        enable;
    logic [3:0]  slotAlive;
    logic [35:0] slotPos;
    logic [8:0]  playerFront;
    logic [7:0]  playerDamage;
    logic [3:0]  moveSCEN;
    logic [3:0]  damageSCEN;
    logic [7:0]  damageIn;
    logic [3:0]  spawn;
    logic [8:0]  enemyFront;
    logic [7:0]  waveCount;
    logic        busy;
    logic        overrun;

    int checks;
    int failures;

    logic [3:0] obsDmg;
    logic [7:0] obsDmgIn;
    logic [3:0] obsMove;
    logic [3:0] obsSpawn;
    int         dmgPulses;
    int         movePulses;
    int         spawnPulses;
    int         busyCycles;
    int         spawnTotal;

    enemy_scheduler #(
        .NUM_SLOTS(4),
        .SPAWN_INTERVAL(8),
        .POS_W(9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gameTick(gameTick),
        .enable(enable),
        .slotAlive(slotAlive),
        .slotPos(slotPos),
        .playerFront(playerFront),
        .playerDamage(playerDamage),
        .moveSCEN(moveSCEN),
        .damageSCEN(damageSCEN),
        .damageIn(damageIn),
        .spawn(spawn),
        .enemyFront(enemyFront),
        .waveCount(waveCount),
        .busy(busy),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulses one gameTick and records the strobes over the fixed 9-cycle window.
    task automatic applyStimulus(input bit doubleTick);
        obsDmg      = '0;
        obsDmgIn    = '0;
        obsMove     = '0;
        obsSpawn    = '0;
        dmgPulses   = 0;
        movePulses  = 0;
        spawnPulses = 0;
        busyCycles  = 0;
        @(negedge clk) gameTick = 1'b1;
        @(posedge clk);
        @(negedge clk) gameTick = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (damageSCEN != 4'd0) dmgPulses++;
            if (moveSCEN != 4'd0) movePulses++;
            if (spawn != 4'd0) spawnPulses++;
            if (busy) busyCycles++;
            if (k == 5) begin
                obsDmg   = damageSCEN;
                obsDmgIn = damageIn;
            end
            if (k == 6) obsMove = moveSCEN;
            if (k == 7) obsSpawn = spawn;
            if (doubleTick && k == 1) gameTick = 1'b1;
            if (doubleTick && k == 2) gameTick = 1'b0;
        end
        spawnTotal += spawnPulses;
        repeat (6) @(posedge clk);
    endtask

    task automatic setPos(input int slot, input logic [8:0] pos);
        slotPos[slot*9 +: 9] = pos;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        spawnTotal   = 0;
        reset        = 1'b0;
        gameTick     = 1'b0;
        enable       = 1'b0;
        slotAlive    = 4'b0000;
        slotPos      = '0;
        playerFront  = 9'd0;
        playerDamage = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_spawn", 32'(spawn), 32'h0);
        checkOutput("rst_move", 32'(moveSCEN), 32'h0);
        checkOutput("rst_dmg", 32'(damageSCEN), 32'h0);
        checkOutput("rst_wave", 32'(waveCount), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_overrun", 32'(overrun), 32'h0);
        @(negedge clk) reset = 1'b1;

        // Tick with enable low must be ignored entirely.
        applyStimulus(1'b0);
        checkOutput("disabled_busy_cycles", 32'(busyCycles), 32'd0);
        checkOutput("disabled_overrun", 32'(overrun), 32'h0);

        // All dead: first spawn lands on the 8th accepted tick.
        enable = 1'b1;
        applyStimulus(1'b0);
        checkOutput("tick1_busy_cycles", 32'(busyCycles), 32'd7);
        checkOutput("empty_front", 32'(enemyFront), 32'd0);
        checkOutput("empty_dmg", 32'(dmgPulses), 32'd0);
        for (int i = 2; i <= 7; i++) applyStimulus(1'b0);
        checkOutput("spawns_before_8th", 32'(spawnTotal), 32'd0);
        applyStimulus(1'b0);
        checkOutput("spawn_8th", 32'(obsSpawn), 32'b0001);
        checkOutput("spawn_8th_pulses", 32'(spawnPulses), 32'd1);
        checkOutput("wave_after_first", 32'(waveCount), 32'd1);

        // Tie at 70 between slot1 and slot3: lower index is targeted.
        slotAlive = 4'b1011;
        setPos(0, 9'd40);
        setPos(1, 9'd70);
        setPos(2, 9'd200);
        setPos(3, 9'd70);
        playerFront  = 9'd70;
        playerDamage = 8'h20;
        applyStimulus(1'b0);
        checkOutput("tie_front", 32'(enemyFront), 32'd70);
        checkOutput("tie_dmg_target", 32'(obsDmg), 32'b0010);
        checkOutput("tie_dmg_value", 32'(obsDmgIn), 32'h20);
        checkOutput("tie_dmg_pulses", 32'(dmgPulses), 32'd1);
        checkOutput("tie_move", 32'(obsMove), 32'b1011);
        checkOutput("tie_move_pulses", 32'(movePulses), 32'd1);

        playerFront = 9'd71;
        applyStimulus(1'b0);
        checkOutput("out_of_reach_dmg", 32'(dmgPulses), 32'd0);
        checkOutput("out_of_reach_dmgin", 32'(obsDmgIn), 32'h0);

        setPos(3, 9'd90);
        playerFront  = 9'd10;
        playerDamage = 8'h05;
        applyStimulus(1'b0);
        checkOutput("new_front", 32'(enemyFront), 32'd90);
        checkOutput("new_target", 32'(obsDmg), 32'b1000);
        checkOutput("new_dmg_value", 32'(obsDmgIn), 32'h05);

        playerDamage = 8'h00;
        applyStimulus(1'b0);
        checkOutput("zero_damage", 32'(dmgPulses), 32'd0);

        // Counter is at 4; three ticks bring it to 7, then a full board blocks the spawn.
        slotAlive = 4'b1111;
        spawnTotal = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0);
        checkOutput("full_no_spawn", 32'(spawnTotal), 32'd0);
        checkOutput("full_wave_hold", 32'(waveCount), 32'd1);
        slotAlive = 4'b1011;
        applyStimulus(1'b0);
        checkOutput("pending_spawn", 32'(obsSpawn), 32'b0100);
        checkOutput("pending_wave", 32'(waveCount), 32'd2);

        // Second tick two cycles in is dropped and flagged.
        applyStimulus(1'b1);
        checkOutput("overrun_flag", 32'(overrun), 32'h1);
        checkOutput("overrun_move_pulses", 32'(movePulses), 32'd1);
        checkOutput("overrun_move", 32'(obsMove), 32'b1011);
        checkOutput("overrun_busy_cycles", 32'(busyCycles), 32'd7);

        // Reset asserted while the sequencer sits in QMove.
        slotAlive = 4'b0101;
        setPos(0, 9'd50);
        setPos(2, 9'd30);
        playerFront  = 9'd0;
        playerDamage = 8'h07;
        @(negedge clk) gameTick = 1'b1;
        @(posedge clk);
        @(negedge clk) gameTick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pre_reset_dmg", 32'(damageSCEN), 32'b0001);
        #1 reset = 1'b0;
        #1;
        checkOutput("midrst_dmg", 32'(damageSCEN), 32'h0);
        checkOutput("midrst_dmgin", 32'(damageIn), 32'h0);
        checkOutput("midrst_move", 32'(moveSCEN), 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_overrun", 32'(overrun), 32'h0);
        checkOutput("midrst_wave", 32'(waveCount), 32'h0);
        checkOutput("midrst_front", 32'(enemyFront), 32'h0);
        spawnPulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (spawn != 4'd0 || moveSCEN != 4'd0) spawnPulses++;
        end
        checkOutput("midrst_no_strobes", 32'(spawnPulses), 32'd0);
        @(negedge clk) reset = 1'b1;

        // Counter must restart from zero after reset.
        playerDamage = 8'h00;
        spawnTotal = 0;
        for (int i = 0; i < 7; i++) applyStimulus(1'b0);
        checkOutput("postrst_no_early_spawn", 32'(spawnTotal), 32'd0);
        applyStimulus(1'b0);
        checkOutput("postrst_spawn", 32'(obsSpawn), 32'b0010);
        checkOutput("postrst_wave", 32'(waveCount), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
